nmi_hotkey_events: RTL and testbench

//  Producer side of the user-event/NMI handshake: turns decoded keyboard activity into the 5-bit

---
 rtl/nmi_hotkey_events_pkg.sv | 33 +++
 rtl/nmi_hotkey_events_kbd_mod_tracker.sv | 51 +++++
 rtl/nmi_hotkey_events.sv | 110 +++++++++++
 tb/tb_nmi_hotkey_events.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/nmi_hotkey_events_pkg.sv
// Shared hotkey/NMI config: ZX-Uno register address, PS/2 set-2 scancodes and Fkey decode helper.
package nmi_hotkey_events_pkg;

    localparam logic [7:0] NMIEVMASK = 8'h08;

    localparam logic [7:0] SC_CTRL = 8'h14;
    localparam logic [7:0] SC_ALT  = 8'h11;
    localparam logic [7:0] SC_F1   = 8'h05;
    localparam logic [7:0] SC_F2   = 8'h06;
    localparam logic [7:0] SC_F3   = 8'h04;
    localparam logic [7:0] SC_F4   = 8'h0C;
    localparam logic [7:0] SC_F5   = 8'h03;

    typedef struct packed {
        logic       hit;
        logic [2:0] idx;
    } fkey_dec_t;

    function automatic fkey_dec_t fkey_decode(input logic [7:0] code);
        fkey_dec_t d;
        d = '0;
        case (code)
            SC_F1: d = '{hit: 1'b1, idx: 3'd0};
            SC_F2: d = '{hit: 1'b1, idx: 3'd1};
            SC_F3: d = '{hit: 1'b1, idx: 3'd2};
            SC_F4: d = '{hit: 1'b1, idx: 3'd3};
            SC_F5: d = '{hit: 1'b1, idx: 3'd4};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/nmi_hotkey_events_kbd_mod_tracker.sv
// Tracks Ctrl/Alt (left and right) and F1..F5 held state from the decoded keyboard event stream.
module nmi_hotkey_events_kbd_mod_tracker
    import nmi_hotkey_events_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_kbd_valid,
    input  logic [7:0] i_kbd_code,
    input  logic       i_kbd_extended,
    input  logic       i_kbd_released,
    output logic       o_ctrl,
    output logic       o_alt,
    output logic [4:0] o_fkey_held
);

    logic       r_ctrl_l, r_ctrl_r, r_alt_l, r_alt_r;
    logic [4:0] r_fkey_held;
    fkey_dec_t  w_dec;
    logic [4:0] w_onehot;

    assign w_dec    = fkey_decode(i_kbd_code);
    assign w_onehot = 5'b00001 << w_dec.idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctrl_l    <= 1'b0;
            r_ctrl_r    <= 1'b0;
            r_alt_l     <= 1'b0;
            r_alt_r     <= 1'b0;
            r_fkey_held <= '0;
        end else if (i_kbd_valid) begin
            if (i_kbd_code == SC_CTRL) begin
                if (i_kbd_extended) r_ctrl_r <= !i_kbd_released;
                else                r_ctrl_l <= !i_kbd_released;
            end
            if (i_kbd_code == SC_ALT) begin
                if (i_kbd_extended) r_alt_r <= !i_kbd_released;
                else                r_alt_l <= !i_kbd_released;
            end
            if (!i_kbd_extended && w_dec.hit) begin
                if (i_kbd_released) r_fkey_held <= r_fkey_held & ~w_onehot;
                else                r_fkey_held <= r_fkey_held | w_onehot;
            end
        end
    end

    assign o_ctrl      = r_ctrl_l | r_ctrl_r;
    assign o_alt       = r_alt_l | r_alt_r;
    assign o_fkey_held = r_fkey_held;

endmodule

// File: rtl/nmi_hotkey_events.sv
// Ctrl+Alt+F1..F5 hotkeys -> one-hot userevents request, held until the NMI pager acks or times out.
module nmi_hotkey_events
    import nmi_hotkey_events_pkg::*;
#(
    parameter logic [23:0] ACK_TIMEOUT = 24'd3_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       kbd_valid,
    input  logic [7:0] kbd_code,
    input  logic       kbd_extended,
    input  logic       kbd_released,
    input  logic [7:0] zxuno_addr,
    input  logic       zxuno_regrd,
    input  logic       zxuno_regwr,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       oe_n,
    input  logic       page_configrom_active,
    output logic [4:0] userevents
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    logic [1:0]  r_state;
    logic [4:0]  r_mask;
    logic [4:0]  r_userevents;
    logic [23:0] r_timer;

    logic        w_ctrl, w_alt;
    logic [4:0]  w_fkey_held;
    fkey_dec_t   w_dec;
    logic [4:0]  w_onehot;
    logic        w_combo;
    logic        w_timeout;
    logic        w_unused_din;

    nmi_hotkey_events_kbd_mod_tracker u_tracker (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_kbd_valid    (kbd_valid),
        .i_kbd_code     (kbd_code),
        .i_kbd_extended (kbd_extended),
        .i_kbd_released (kbd_released),
        .o_ctrl         (w_ctrl),
        .o_alt          (w_alt),
        .o_fkey_held    (w_fkey_held)
    );

    assign w_dec    = fkey_decode(kbd_code);
    assign w_onehot = 5'b00001 << w_dec.idx;

    // Modifier flags are the registered state from before this key event.
    assign w_combo = kbd_valid && !kbd_extended && !kbd_released && w_dec.hit
                     && w_ctrl && w_alt && |(w_onehot & r_mask) && !page_configrom_active;

    assign w_timeout = (ACK_TIMEOUT != 24'd0) && (r_timer == ACK_TIMEOUT - 24'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_userevents <= '0;
            r_timer      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_combo) begin
                        r_userevents <= w_onehot;
                        r_timer      <= '0;
                        r_state      <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (r_timer != '1) r_timer <= r_timer + 24'd1;
                    if (page_configrom_active) begin
                        r_userevents <= '0;
                        r_state      <= ST_SERVICE;
                    end else if (w_timeout) begin
                        r_userevents <= '0;
                        r_state      <= ST_RELEASE;
                    end
                end
                ST_SERVICE: begin
                    if (!page_configrom_active) r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (w_fkey_held == '0 && !(w_ctrl && w_alt)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= '1;
        end else if (zxuno_regwr && zxuno_addr == NMIEVMASK) begin
            r_mask <= din[4:0];
        end
    end

    assign w_unused_din = ^din[7:5];
    assign dout         = {3'b000, r_mask};
    assign oe_n         = !(zxuno_addr == NMIEVMASK && zxuno_regrd);
    assign userevents   = r_userevents;

endmodule

// File: tb/tb_nmi_hotkey_events.sv
// Directed bench for nmi_hotkey_events: hotkey combos, masking, ack/timeout handshake, reset.
module tb_nmi_hotkey_events;
    import nmi_hotkey_events_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       kbd_valid;
    logic [7:0] kbd_code;
    logic       kbd_extended;
    logic       kbd_released;
    logic [7:0] zxuno_addr;
    logic       zxuno_regrd;
    logic       zxuno_regwr;
    logic [7:0] din;
    logic [7:0] dout;
    logic       oe_n;
    logic       page_configrom_active;
    logic [4:0] userevents;

    int n_asserts = 0;
    int n_fail    = 0;
    int hi_cnt;

    always #5 clk = ~clk;

    nmi_hotkey_events #(.ACK_TIMEOUT(24'd16)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .kbd_valid             (kbd_valid),
        .kbd_code              (kbd_code),
        .kbd_extended          (kbd_extended),
        .kbd_released          (kbd_released),
        .zxuno_addr            (zxuno_addr),
        .zxuno_regrd           (zxuno_regrd),
        .zxuno_regwr           (zxuno_regwr),
        .din                   (din),
        .dout                  (dout),
        .oe_n                  (oe_n),
        .page_configrom_active (page_configrom_active),
        .userevents            (userevents)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) @(negedge clk);
    endtask

    // Presents one key event for a single clock; returns on the following negedge.
    task automatic key(input logic [7:0] code, input logic ext, input logic rel);
        @(negedge clk);
        kbd_valid    = 1'b1;
        kbd_code     = code;
        kbd_extended = ext;
        kbd_released = rel;
        @(negedge clk);
        kbd_valid    = 1'b0;
        kbd_extended = 1'b0;
        kbd_released = 1'b0;
    endtask

    task automatic wr_mask(input logic [7:0] v);
        @(negedge clk);
        zxuno_addr  = NMIEVMASK;
        din         = v;
        zxuno_regwr = 1'b1;
        @(negedge clk);
        zxuno_regwr = 1'b0;
        zxuno_addr  = 8'h00;
    endtask

    initial begin
        rst_n = 1'b0; kbd_valid = 1'b0; kbd_code = 8'h00; kbd_extended = 1'b0;
        kbd_released = 1'b0; zxuno_addr = 8'h00; zxuno_regrd = 1'b0; zxuno_regwr = 1'b0;
        din = 8'h00; page_configrom_active = 1'b0;
        tick(2);
        chk("reset_userevents", userevents, 5'b00000);
        chk("reset_dout", dout, 8'h1F);
        chk("reset_oe_n", oe_n, 1'b1);
        rst_n = 1'b1;
        tick(1);

        // 1: Ctrl_L+Alt_L+F5, held until ack
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_F5, 1'b0, 1'b0);
        chk("t1_ctrl_only_no_event", userevents, 5'b00000);
        key(SC_F5, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F5, 1'b0, 1'b0);
        chk("t1_event", userevents, 5'b10000);
        tick(5);
        chk("t1_hold", userevents, 5'b10000);
        page_configrom_active = 1'b1;
        tick(1);
        chk("t1_ack_clears", userevents, 5'b00000);
        tick(3);
        chk("t1_service_low", userevents, 5'b00000);
        page_configrom_active = 1'b0;
        key(SC_F5, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b1);
        key(SC_CTRL, 1'b0, 1'b1);
        tick(2);

        // 2: mask out F1, read back mask
        wr_mask(8'h1E);
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F1, 1'b0, 1'b0);
        chk("t2_masked_no_event", userevents, 5'b00000);
        tick(1);
        chk("t2_masked_still_none", userevents, 5'b00000);
        zxuno_addr = NMIEVMASK; zxuno_regrd = 1'b1;
        #1;
        chk("t2_dout", dout, 8'h1E);
        chk("t2_oe_n_rd", oe_n, 1'b0);
        zxuno_addr = 8'h09;
        #1;
        chk("t2_oe_n_other_addr", oe_n, 1'b1);
        zxuno_addr = 8'h00; zxuno_regrd = 1'b0;
        key(SC_F1, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b1);
        key(SC_CTRL, 1'b0, 1'b1);
        wr_mask(8'hFF);
        chk("t2_mask_restored", dout, 8'h1F);

        // 3: right modifiers + F3, timeout after 16 cycles
        key(SC_CTRL, 1'b1, 1'b0);
        key(SC_ALT, 1'b1, 1'b0);
        key(SC_F3, 1'b0, 1'b0);
        chk("t3_event", userevents, 5'b00100);
        hi_cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (userevents == 5'b00100) hi_cnt++;
        end
        chk("t3_high_cycles", hi_cnt, 16);
        chk("t3_timeout_clears", userevents, 5'b00000);
        key(SC_F3, 1'b0, 1'b0);
        chk("t3_repeat_ignored", userevents, 5'b00000);
        key(SC_F1, 1'b0, 1'b0);
        chk("t3_other_combo_ignored", userevents, 5'b00000);
        key(SC_F1, 1'b0, 1'b1);
        key(SC_F3, 1'b0, 1'b1);
        key(SC_ALT, 1'b1, 1'b1);
        key(SC_CTRL, 1'b1, 1'b1);
        tick(2);

        // 4: combo while ack high is dropped
        page_configrom_active = 1'b1;
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F4, 1'b0, 1'b0);
        chk("t4_ack_high_no_event", userevents, 5'b00000);
        page_configrom_active = 1'b0;
        tick(3);
        chk("t4_no_late_event", userevents, 5'b00000);
        key(SC_F4, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b1);
        key(SC_CTRL, 1'b0, 1'b1);
        tick(2);

        // 5: F2 autorepeat after service yields one event only
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F2, 1'b0, 1'b0);
        chk("t5_event", userevents, 5'b00010);
        page_configrom_active = 1'b1;
        tick(1);
        chk("t5_ack_clears", userevents, 5'b00000);
        page_configrom_active = 1'b0;
        tick(1);
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            key(SC_F2, 1'b0, 1'b0);
            if (userevents != 5'b00000) hi_cnt++;
        end
        tick(2);
        chk("t5_repeat_events", hi_cnt, 0);
        chk("t5_still_none", userevents, 5'b00000);
        key(SC_F2, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b1);
        key(SC_CTRL, 1'b0, 1'b1);
        tick(2);

        // 6: mask write mid-ASSERT keeps event; async reset clears it
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F1, 1'b0, 1'b0);
        chk("t6_event", userevents, 5'b00001);
        wr_mask(8'h00);
        chk("t6_write_keeps_event", userevents, 5'b00001);
        chk("t6_mask_zero", dout, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_rst_userevents", userevents, 5'b00000);
        chk("t6_async_rst_mask", dout, 8'h1F);
        tick(1);
        rst_n = 1'b1;
        key(SC_F1, 1'b0, 1'b1);
        key(SC_ALT, 1'b0, 1'b1);
        key(SC_CTRL, 1'b0, 1'b1);
        tick(1);
        key(SC_CTRL, 1'b0, 1'b0);
        key(SC_ALT, 1'b0, 1'b0);
        key(SC_F1, 1'b0, 1'b0);
        chk("t6_idle_after_reset", userevents, 5'b00001);
        page_configrom_active = 1'b1;
        tick(1);
        chk("t6_final_ack", userevents, 5'b00000);
        page_configrom_active = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
